// File: rtl/ysyx_22040127_writeback_pkg.sv
// Shared definitions for the writeback stage: mem_to_wb bus layout, CSR addresses and op decode.
// Consumed by ysyx_22040127_writeback_if, ysyx_22040127_csr_file and ysyx_22040127_writeback.
package ysyx_22040127_writeback_pkg;

  localparam int XLEN  = 64;
  localparam int PC_W  = 32;
  localparam int BUS_W = 322;

  localparam logic [XLEN-1:0] MSTATUS_RV_DEFAULT = 64'ha00001800;
  localparam logic [XLEN-1:0] MCAUSE_ECALL_M     = 64'd11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  // Field order is MSB first and must match the memory stage's packing exactly.
  typedef struct packed {
    logic             ebreak;
    logic             memwrite;
    logic [XLEN-1:0]  diff_data;
    logic [XLEN-1:0]  diff_addr;
    logic [11:0]      des_csr;
    logic [XLEN-1:0]  src1;
    logic [4:0]       rs1;
    logic             csr_we;
    logic             mret;
    logic             ecall;
    logic             csrrw;
    logic             csrrs;
    logic             csrrc;
    logic             csrrwi;
    logic             csrrsi;
    logic             csrrci;
    logic [PC_W-1:0]  pc;
    logic             reg_wen;
    logic [4:0]       rd;
    logic [XLEN-1:0]  wdata;
  } wb_bus_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE,
    CSR_OP_RW,
    CSR_OP_RS,
    CSR_OP_RC
  } csr_op_e;

  function automatic csr_op_e csr_op_decode(input logic rw, input logic rs, input logic rc);
    if (rw)      return CSR_OP_RW;
    else if (rs) return CSR_OP_RS;
    else if (rc) return CSR_OP_RC;
    else         return CSR_OP_NONE;
  endfunction

endpackage

// File: rtl/ysyx_22040127_writeback_if.sv
// Memory-to-writeback handshake: valid/bus forward, allowin back.
interface ysyx_22040127_writeback_if;
  import ysyx_22040127_writeback_pkg::*;

  logic    mem_to_wb_valid;
  wb_bus_t mem_to_wb_bus;
  logic    wb_allowin;

  modport master (output mem_to_wb_valid, output mem_to_wb_bus, input  wb_allowin);
  modport slave  (input  mem_to_wb_valid, input  mem_to_wb_bus, output wb_allowin);

endinterface

// File: rtl/ysyx_22040127_csr_file.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause): read mux, csr ops, ecall/mret update and redirect.
module ysyx_22040127_csr_file
  import ysyx_22040127_writeback_pkg::*;
#(
  parameter logic [XLEN-1:0] MSTATUS_RV = MSTATUS_RV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_retire,
  input  logic             i_ecall,
  input  logic             i_mret,
  input  logic             i_csr_we,
  input  csr_op_e          i_op,
  input  logic [11:0]      i_addr,
  input  logic [XLEN-1:0]  i_src,
  input  logic [PC_W-1:0]  i_pc,
  output logic [XLEN-1:0]  o_rdata,
  output logic             o_redirect_valid,
  output logic [PC_W-1:0]  o_redirect_pc
);

  logic [XLEN-1:0] r_mstatus, r_mtvec, r_mepc, r_mcause;
  logic [XLEN-1:0] w_new;
  logic            w_write;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    o_rdata = '0;
    unique case (i_addr)
      CSR_MSTATUS: o_rdata = r_mstatus;
      CSR_MTVEC:   o_rdata = r_mtvec;
      CSR_MEPC:    o_rdata = r_mepc;
      CSR_MCAUSE:  o_rdata = r_mcause;
      default:     o_rdata = '0;
    endcase

    w_new = o_rdata;
    unique case (i_op)
      CSR_OP_RW: w_new = i_src;
      CSR_OP_RS: w_new = o_rdata | i_src;
      CSR_OP_RC: w_new = o_rdata & ~i_src;
      default:   w_new = o_rdata;
    endcase
  end

  // Set/clear with a zero source is a pure read and must not touch the CSR.
  assign w_write = i_retire && i_csr_we && (i_op != CSR_OP_NONE) &&
                   !(((i_op == CSR_OP_RS) || (i_op == CSR_OP_RC)) && (i_src == '0));

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_mstatus <= MSTATUS_RV;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (i_retire && i_ecall) begin
      r_mepc              <= {{(XLEN-PC_W){1'b0}}, i_pc};
      r_mcause            <= MCAUSE_ECALL_M;
      r_mstatus[MPIE_BIT] <= r_mstatus[MIE_BIT];
      r_mstatus[MIE_BIT]  <= 1'b0;
    end else if (i_retire && i_mret) begin
      r_mstatus[MIE_BIT]  <= r_mstatus[MPIE_BIT];
      r_mstatus[MPIE_BIT] <= 1'b1;
    end else if (w_write) begin
      unique case (i_addr)
        CSR_MSTATUS: r_mstatus <= w_new;
        CSR_MTVEC:   r_mtvec   <= w_new;
        CSR_MEPC:    r_mepc    <= w_new;
        CSR_MCAUSE:  r_mcause  <= w_new;
        default:     ;
      endcase
    end
  end

  assign o_redirect_valid = i_retire && (i_ecall || i_mret);
  assign o_redirect_pc    = !o_redirect_valid ? '0 :
                            i_ecall ? r_mtvec[PC_W-1:0] : r_mepc[PC_W-1:0];

endmodule

// File: rtl/ysyx_22040127_writeback.sv
// Writeback stage: pipeline register, GPR write port, CSR file, ebreak halt and retire counter.
// Optional macro YSYX_22040127_DIFFTEST_EN adds registered difftest commit outputs.
module ysyx_22040127_writeback
  import ysyx_22040127_writeback_pkg::*;
#(
  parameter logic [XLEN-1:0] MSTATUS_RV = MSTATUS_RV_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22040127_writeback_if.slave   mem_to_wb,
  output logic                       o_rf_we,
  output logic [4:0]                 o_rf_waddr,
  output logic [XLEN-1:0]            o_rf_wdata,
  output logic                       o_redirect_valid,
  output logic [PC_W-1:0]            o_redirect_pc,
  output logic                       o_halt,
  output logic [PC_W-1:0]            o_halt_pc,
  output logic [63:0]                o_retire_cnt
`ifdef YSYX_22040127_DIFFTEST_EN
  ,
  output logic                       o_diff_commit,
  output logic [PC_W-1:0]            o_diff_pc,
  output logic                       o_diff_memwrite,
  output logic [XLEN-1:0]            o_diff_addr,
  output logic [XLEN-1:0]            o_diff_data
`endif
);

  logic            r_wb_valid;
  wb_bus_t         r_bus;
  logic            r_halt;
  logic [PC_W-1:0] r_halt_pc;
  logic [63:0]     r_retire_cnt;

  logic            w_retire;
  logic            w_csr_any;
  logic            w_src_imm;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_csr_rdata;
  csr_op_e         w_op;

  assign mem_to_wb.wb_allowin = !r_wb_valid || !r_halt;

  // Reset cancels the in-flight instruction's side effects in the same cycle.
  assign w_retire  = r_wb_valid && !r_halt && !rst;
  assign w_csr_any = r_bus.csrrw  | r_bus.csrrs  | r_bus.csrrc |
                     r_bus.csrrwi | r_bus.csrrsi | r_bus.csrrci;
  assign w_src_imm = r_bus.csrrwi | r_bus.csrrsi | r_bus.csrrci;
  assign w_src     = w_src_imm ? {{(XLEN-5){1'b0}}, r_bus.rs1} : r_bus.src1;
  assign w_op      = csr_op_decode(r_bus.csrrw | r_bus.csrrwi,
                                   r_bus.csrrs | r_bus.csrrsi,
                                   r_bus.csrrc | r_bus.csrrci);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bus register is reset too so rf_waddr/rf_wdata read 0 out of reset.
      r_wb_valid   <= 1'b0;
      r_bus        <= '0;
      r_halt       <= 1'b0;
      r_halt_pc    <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (mem_to_wb.wb_allowin) r_wb_valid <= mem_to_wb.mem_to_wb_valid;
      if (mem_to_wb.wb_allowin && mem_to_wb.mem_to_wb_valid) r_bus <= mem_to_wb.mem_to_wb_bus;
      if (w_retire) r_retire_cnt <= r_retire_cnt + 64'd1;
      if (w_retire && r_bus.ebreak) begin
        r_halt    <= 1'b1;
        r_halt_pc <= r_bus.pc;
      end
    end
  end

  ysyx_22040127_csr_file #(.MSTATUS_RV(MSTATUS_RV)) u_csr_file (
    .clk              (clk),
    .rst              (rst),
    .i_retire         (w_retire),
    .i_ecall          (r_bus.ecall),
    .i_mret           (r_bus.mret),
    .i_csr_we         (r_bus.csr_we),
    .i_op             (w_op),
    .i_addr           (r_bus.des_csr),
    .i_src            (w_src),
    .i_pc             (r_bus.pc),
    .o_rdata          (w_csr_rdata),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  assign o_rf_we      = w_retire && r_bus.reg_wen && (r_bus.rd != 5'd0);
  assign o_rf_waddr   = r_bus.rd;
  assign o_rf_wdata   = w_csr_any ? w_csr_rdata : r_bus.wdata;
  assign o_halt       = r_halt;
  assign o_halt_pc    = r_halt_pc;
  assign o_retire_cnt = r_retire_cnt;

`ifdef YSYX_22040127_DIFFTEST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_diff_commit   <= 1'b0;
      o_diff_pc       <= '0;
      o_diff_memwrite <= 1'b0;
      o_diff_addr     <= '0;
      o_diff_data     <= '0;
    end else begin
      o_diff_commit   <= w_retire;
      o_diff_pc       <= r_bus.pc;
      o_diff_memwrite <= r_bus.memwrite;
      o_diff_addr     <= r_bus.diff_addr;
      o_diff_data     <= r_bus.diff_data;
    end
  end
`else
  logic w_unused_diff;
  assign w_unused_diff = ^{r_bus.memwrite, r_bus.diff_addr, r_bus.diff_data};
`endif

endmodule
